guardian_module: RTL and testbench

- Per-block health monitor for one compute block in the self-healing fabric.
- Tracks running baselines of on-die temperature and voltage codes plus the raw timing-slack margin, and combines deviations into a 16-bit anomaly score.
- Raises alert_valid when the score crosses a threshold.
- Tags every output with a static block identifier so a central healing controller can locate the faulty block.

---
 rtl/guardian_pkg.sv | 31 +++
 rtl/guardian_ema_channel.sv | 37 +++
 rtl/guardian_module.sv | 97 +++++++++
 tb/tb_guardian_module.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/guardian_pkg.sv
// guardian_pkg: shared widths, default tuning constants, stage-2 record and saturating add.
package guardian_pkg;
    localparam int SENSOR_W = 12;
    localparam int MARGIN_W = 16;
    localparam int SCORE_W  = 16;
    localparam int ID_W     = 16;

    localparam int DEF_EMA_SHIFT     = 3;
    localparam int DEF_TEMP_WEIGHT   = 4;
    localparam int DEF_VOLT_WEIGHT   = 2;
    localparam int DEF_TIMING_WEIGHT = 1;
    localparam int DEF_TIMING_MIN    = 64;
    localparam int DEF_ALERT_THRESH  = 256;
    localparam int DEF_WARMUP        = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef struct packed {
        logic                valid;
        logic                warm;
        logic [SENSOR_W-1:0] dev_t;
        logic [SENSOR_W-1:0] dev_v;
        logic [MARGIN_W-1:0] dev_m;
    } stage2_t;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {17'd0, SCORE_MAX}) ? SCORE_MAX : s[SCORE_W-1:0];
    endfunction
endpackage

// File: rtl/guardian_ema_channel.sv
// guardian_ema_channel: 12-bit running baseline (EMA) with first-sample load and |sample - baseline| output.
module guardian_ema_channel
    import guardian_pkg::*;
#(
    parameter int EMA_SHIFT = DEF_EMA_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                upd,
    input  logic [SENSOR_W-1:0] code,
    input  logic [SENSOR_W-1:0] sample,
    output logic [SENSOR_W-1:0] dev
);
    logic [SENSOR_W-1:0] base;
    logic                ready;
    logic signed [SENSOR_W:0] diff, step;
    logic [SENSOR_W:0] mag;

    assign diff = $signed({1'b0, sample}) - $signed({1'b0, base});
    assign step = diff >>> EMA_SHIFT;
    assign mag  = diff[SENSOR_W] ? -diff : diff;
    assign dev  = mag[SENSOR_W-1:0];

    // Floored step always lands between base and sample, so the 12-bit sum never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            base  <= '0;
            ready <= 1'b0;
        end else if (!ready && load) begin
            base  <= code;
            ready <= 1'b1;
        end else if (upd) begin
            base <= base + step[SENSOR_W-1:0];
        end
    end
endmodule

// File: rtl/guardian_module.sv
// guardian_module: per-block health monitor scoring temperature, voltage and timing deviations.
// Define GUARDIAN_STICKY_ALERT_EN to latch alert_valid and hold the peak score until rst or enable=0.
module guardian_module
    import guardian_pkg::*;
#(
    parameter int BLOCK_ID      = 0,
    parameter int EMA_SHIFT     = DEF_EMA_SHIFT,
    parameter int TEMP_WEIGHT   = DEF_TEMP_WEIGHT,
    parameter int VOLT_WEIGHT   = DEF_VOLT_WEIGHT,
    parameter int TIMING_WEIGHT = DEF_TIMING_WEIGHT,
    parameter int TIMING_MIN    = DEF_TIMING_MIN,
    parameter int ALERT_THRESH  = DEF_ALERT_THRESH,
    parameter int WARMUP        = DEF_WARMUP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SENSOR_W-1:0] temp_code,
    input  logic [SENSOR_W-1:0] volt_code,
    input  logic [MARGIN_W-1:0] timing_margin,
    output logic                alert_valid,
    output logic [SCORE_W-1:0]  anomaly_score,
    output logic [ID_W-1:0]     block_id
);
    logic [SENSOR_W-1:0] temp_s, volt_s, dev_t, dev_v;
    logic [MARGIN_W-1:0] margin_s, dev_m;
    logic [15:0]         warm_cnt;
    logic                v1, w1, upd, hit;
    stage2_t             s2;
    logic [31:0]         sum_tv, term_m;
    logic [SCORE_W-1:0]  score_c;

    assign block_id = ID_W'(BLOCK_ID);
    assign upd      = v1 && enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            w1       <= 1'b0;
            temp_s   <= '0;
            volt_s   <= '0;
            margin_s <= '0;
            warm_cnt <= '0;
        end else begin
            v1 <= enable;
            if (enable) begin
                temp_s   <= temp_code;
                volt_s   <= volt_code;
                margin_s <= timing_margin;
                w1       <= (32'(warm_cnt) + 32'd1) >= 32'(WARMUP);
                if (32'(warm_cnt) < 32'(WARMUP))
                    warm_cnt <= warm_cnt + 16'd1;
            end
        end
    end

    guardian_ema_channel #(.EMA_SHIFT(EMA_SHIFT)) u_temp (
        .clk(clk), .rst(rst), .load(enable), .upd(upd),
        .code(temp_code), .sample(temp_s), .dev(dev_t)
    );

    guardian_ema_channel #(.EMA_SHIFT(EMA_SHIFT)) u_volt (
        .clk(clk), .rst(rst), .load(enable), .upd(upd),
        .code(volt_code), .sample(volt_s), .dev(dev_v)
    );

    assign dev_m = (32'(margin_s) < 32'(TIMING_MIN)) ? MARGIN_W'(TIMING_MIN) - margin_s : '0;

    // Dropping enable kills the in-flight sample so the baselines stay frozen exactly while low.
    always_ff @(posedge clk) begin
        if (rst)
            s2 <= '0;
        else
            s2 <= '{valid: upd, warm: w1, dev_t: dev_t, dev_v: dev_v, dev_m: dev_m};
    end

    assign sum_tv  = 32'(TEMP_WEIGHT) * 32'(s2.dev_t) + 32'(VOLT_WEIGHT) * 32'(s2.dev_v);
    assign term_m  = 32'(TIMING_WEIGHT) * 32'(s2.dev_m);
    assign score_c = sat_add(sum_tv, term_m);
    assign hit     = s2.warm && (32'(score_c) >= 32'(ALERT_THRESH));

    always_ff @(posedge clk) begin
        if (rst || !s2.valid) begin
            anomaly_score <= '0;
            alert_valid   <= 1'b0;
        end
`ifdef GUARDIAN_STICKY_ALERT_EN
        else if (alert_valid) begin
            anomaly_score <= (score_c > anomaly_score) ? score_c : anomaly_score;
        end
`endif
        else begin
            anomaly_score <= score_c;
            alert_valid   <= hit;
        end
    end
endmodule

// File: tb/tb_guardian_module.sv
// tb_guardian_module: directed checks of three guardian_module instances with different weights.
module tb_guardian_module;
    logic        clk = 1'b0;
    logic        rst, enable;
    logic [11:0] temp_code, volt_code;
    logic [15:0] timing_margin;
    logic        alert [3];
    logic [15:0] score [3];
    logic [15:0] id    [3];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    guardian_module #(.BLOCK_ID(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .temp_code(temp_code), .volt_code(volt_code),
        .timing_margin(timing_margin), .alert_valid(alert[0]), .anomaly_score(score[0]), .block_id(id[0])
    );

    guardian_module #(.BLOCK_ID(6), .TIMING_WEIGHT(4)) dut_t (
        .clk(clk), .rst(rst), .enable(enable), .temp_code(temp_code), .volt_code(volt_code),
        .timing_margin(timing_margin), .alert_valid(alert[1]), .anomaly_score(score[1]), .block_id(id[1])
    );

    guardian_module #(.BLOCK_ID(7), .TEMP_WEIGHT(16), .VOLT_WEIGHT(16), .TIMING_WEIGHT(16)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .temp_code(temp_code), .volt_code(volt_code),
        .timing_margin(timing_margin), .alert_valid(alert[2]), .anomaly_score(score[2]), .block_id(id[2])
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input logic [11:0] t, input logic [11:0] v, input logic [15:0] m);
        temp_code     = t;
        volt_code     = v;
        timing_margin = m;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        apply(12'd30, 12'd2048, 16'd200);
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        apply(12'd30, 12'd2048, 16'd200);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (score[i] !== 16'd0 || alert[i] !== 1'b0) begin
                $display("FAIL reset[%0d] score=%0d alert=%b expected 0/0", i, score[i], alert[i]);
                errors++;
            end
            checks++;
            if (id[i] !== 16'(5 + i)) begin
                $display("FAIL reset_id[%0d] got=%0d expected=%0d", i, id[i], 5 + i);
                errors++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_steady();
        enable = 1'b1;
        apply(12'd30, 12'd2048, 16'd200);
        for (int k = 0; k < 20; k++) begin
            tick(1);
            checks++;
            if (score[0] !== 16'd0 || alert[0] !== 1'b0) begin
                $display("FAIL steady cycle %0d score=%0d alert=%b expected 0/0", k, score[0], alert[0]);
                errors++;
            end
        end
        checks++;
        if (id[0] !== 16'd5) begin
            $display("FAIL steady_id got=%0d expected=5", id[0]);
            errors++;
        end
    endtask

    task automatic test_temp_spike();
        int   exp_s [7] = '{480, 420, 368, 324, 284, 220, 192};
        logic exp_a [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        apply(12'd150, 12'd2048, 16'd200);
        tick(2);
        for (int k = 0; k < 7; k++) begin
            if (k == 3) temp_code = 12'd32;
            tick(1);
            checks++;
            if (score[0] !== 16'(exp_s[k]) || alert[0] !== exp_a[k]) begin
                $display("FAIL spike[%0d] score=%0d alert=%b expected %0d/%b", k, score[0], alert[0], exp_s[k], exp_a[k]);
                errors++;
            end
        end
        tick(10);
        checks++;
        if (score[0] >= 16'd256 || alert[0] !== 1'b0) begin
            $display("FAIL spike_recover score=%0d alert=%b expected <256/0", score[0], alert[0]);
            errors++;
        end
    endtask

    task automatic test_timing();
        do_reset();
        enable = 1'b1;
        tick(20);
        apply(12'd30, 12'd2048, 16'd0);
        tick(3);
        checks++;
        if (score[0] !== 16'd64 || alert[0] !== 1'b0) begin
            $display("FAIL timing_w1 score=%0d alert=%b expected 64/0", score[0], alert[0]);
            errors++;
        end
        checks++;
        if (score[1] !== 16'd256 || alert[1] !== 1'b1) begin
            $display("FAIL timing_w4 score=%0d alert=%b expected 256/1", score[1], alert[1]);
            errors++;
        end
        apply(12'd30, 12'd2048, 16'd63);
        tick(3);
        checks++;
        if (score[0] !== 16'd1 || score[1] !== 16'd4 || alert[1] !== 1'b0) begin
            $display("FAIL timing_63 score=%0d/%0d alert=%b expected 1/4/0", score[0], score[1], alert[1]);
            errors++;
        end
        apply(12'd30, 12'd2048, 16'd64);
        tick(3);
        checks++;
        if (score[0] !== 16'd0 || score[1] !== 16'd0) begin
            $display("FAIL timing_64 score=%0d/%0d expected 0/0", score[0], score[1]);
            errors++;
        end
    endtask

    task automatic test_warmup();
        do_reset();
        enable = 1'b1;
        tick(2);
        apply(12'd150, 12'd2048, 16'd200);
        tick(1);
        apply(12'd30, 12'd2048, 16'd200);
        tick(2);
        checks++;
        if (score[0] !== 16'd480 || alert[0] !== 1'b0) begin
            $display("FAIL warmup score=%0d alert=%b expected 480/0", score[0], alert[0]);
            errors++;
        end
        checks++;
        if (score[2] !== 16'd1920 || alert[2] !== 1'b0) begin
            $display("FAIL warmup_w16 score=%0d alert=%b expected 1920/0", score[2], alert[2]);
            errors++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        enable = 1'b1;
        apply(12'd0, 12'd0, 16'd200);
        tick(10);
        apply(12'd4095, 12'd4095, 16'd200);
        tick(3);
        checks++;
        if (score[2] !== 16'd65535 || alert[2] !== 1'b1) begin
            $display("FAIL saturate score=%0d alert=%b expected 65535/1", score[2], alert[2]);
            errors++;
        end
        checks++;
        if (score[0] !== 16'd24570 || alert[0] !== 1'b1) begin
            $display("FAIL full_jump score=%0d alert=%b expected 24570/1", score[0], alert[0]);
            errors++;
        end
        tick(1);
        checks++;
        if (score[0] !== 16'd21504 || score[2] !== 16'd65535) begin
            $display("FAIL full_jump_next score=%0d/%0d expected 21504/65535", score[0], score[2]);
            errors++;
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        tick(20);
        apply(12'd150, 12'd2048, 16'd200);
        tick(3);
        checks++;
        if (score[0] !== 16'd480 || alert[0] !== 1'b1) begin
            $display("FAIL drop_pre score=%0d alert=%b expected 480/1", score[0], alert[0]);
            errors++;
        end
        enable = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (score[i] !== 16'd0 || alert[i] !== 1'b0) begin
                $display("FAIL drop[%0d] score=%0d alert=%b expected 0/0", i, score[i], alert[i]);
                errors++;
            end
        end
        tick(4);
        checks++;
        if (score[0] !== 16'd0 || alert[0] !== 1'b0) begin
            $display("FAIL drop_hold score=%0d alert=%b expected 0/0", score[0], alert[0]);
            errors++;
        end
        enable = 1'b1;
        tick(3);
        checks++;
        if (score[0] !== 16'd368 || alert[0] !== 1'b1) begin
            $display("FAIL reenable score=%0d alert=%b expected 368/1", score[0], alert[0]);
            errors++;
        end
    endtask

    task automatic test_reset_mid_alert();
        rst = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (score[i] !== 16'd0 || alert[i] !== 1'b0 || id[i] !== 16'(5 + i)) begin
                $display("FAIL mid_reset[%0d] score=%0d alert=%b id=%0d expected 0/0/%0d", i, score[i], alert[i], id[i], 5 + i);
                errors++;
            end
        end
        rst = 1'b0;
        tick(3);
        checks++;
        if (score[0] !== 16'd0 || alert[0] !== 1'b0) begin
            $display("FAIL post_reset_reload score=%0d alert=%b expected 0/0", score[0], alert[0]);
            errors++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        apply(12'd30, 12'd2048, 16'd200);
        test_reset();
        test_steady();
        test_temp_spike();
        test_timing();
        test_warmup();
        test_saturation();
        test_enable_drop();
        test_reset_mid_alert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
